// File: rtl/voice_mix_scheduler.sv
// Per-sample voice sequencer: walks enabled voice slots through the shared
// oscillator engine via req/ack and accumulates one mixed sample per frame.
module voice_mix_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8,
  localparam int VW = $clog2(NUM_VOICES),
  localparam int MW = SAMPLE_W + VW
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  sample_now,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  osc_req,
  output logic [VW-1:0]         osc_voice,
  input  logic                  osc_ack,
  input  logic [SAMPLE_W-1:0]   osc_data,
  output logic [MW-1:0]         mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [VW-1:0]           idx_r, idx_next_s;
  logic [NUM_VOICES-1:0]   en_snap_r, en_snap_next_s;
  logic [MW-1:0]           acc_r, acc_next_s;
  logic [MW-1:0]           mix_out_r, mix_out_next_s;
  logic                    overrun_r;
  logic                    slot_en_s;
  logic [MW-1:0]           add_s;
  logic [MW-1:0]           sum_s;

  // Next-state, slot accumulation and frame-result logic
  always_comb begin
    state_next_s   = state_r;
    idx_next_s     = idx_r;
    en_snap_next_s = en_snap_r;
    acc_next_s     = acc_r;
    mix_out_next_s = mix_out_r;
    slot_en_s      = en_snap_r[idx_r];
    // Disabled slots contribute nothing, whatever osc_ack/osc_data show
    add_s          = slot_en_s ? {{VW{1'b0}}, osc_data} : {MW{1'b0}};
    sum_s          = acc_r + add_s;
    case (state_r)
      IDLE: begin
        if (sample_now) begin
          en_snap_next_s = voice_en;
          acc_next_s     = {MW{1'b0}};
          idx_next_s     = {VW{1'b0}};
          state_next_s   = RUN;
        end else begin
          state_next_s   = IDLE;
        end
      end
      RUN: begin
        if (!slot_en_s || osc_ack) begin
          acc_next_s = sum_s;
          // Power-of-two slot count: index wraps back to 0 after the last slot
          idx_next_s = idx_r + VW'(1);
          if (idx_r == VW'(NUM_VOICES - 1)) begin
            mix_out_next_s = sum_s;
            state_next_s   = DONE;
          end else begin
            state_next_s   = RUN;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r   <= IDLE;
      idx_r     <= {VW{1'b0}};
      en_snap_r <= {NUM_VOICES{1'b0}};
      acc_r     <= {MW{1'b0}};
      mix_out_r <= {MW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      idx_r     <= idx_next_s;
      en_snap_r <= en_snap_next_s;
      acc_r     <= acc_next_s;
      mix_out_r <= mix_out_next_s;
      overrun_r <= sample_now && (state_r != IDLE);
    end
  end

  // Request is derived from registered state so reset drops it immediately
  assign osc_req   = (state_r == RUN) && en_snap_r[idx_r];
  assign osc_voice = idx_r;
  assign mix_out   = mix_out_r;
  assign mix_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench for voice_mix_scheduler with a latency-configurable
// oscillator engine model.
module tb_voice_mix_scheduler;

  localparam int NV = 4;
  localparam int SW = 8;
  localparam int VW = 2;
  localparam int MW = 10;

  logic          clk;
  logic          nRst;
  logic          sample_now;
  logic [NV-1:0] voice_en;
  logic          osc_req;
  logic [VW-1:0] osc_voice;
  logic          osc_ack;
  logic [SW-1:0] osc_data;
  logic [MW-1:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;

  int err_cnt   = 0;
  int chk_cnt   = 0;
  int cyc       = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int ovr_cnt   = 0;
  int ovr_cyc   = 0;
  int t_start   = 0;
  int vbase     = 0;
  int obase     = 0;
  int exp_q[$];
  logic [NV-1:0] req_mask   = '0;
  logic          prev_req   = 1'b0;
  logic          prev_ack   = 1'b0;
  logic [VW-1:0] prev_voice = '0;
  logic [SW-1:0] data_tbl [NV];

  voice_mix_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW)) dut (
    .clk(clk), .nRst(nRst), .sample_now(sample_now), .voice_en(voice_en),
    .osc_req(osc_req), .osc_voice(osc_voice), .osc_ack(osc_ack),
    .osc_data(osc_data), .mix_out(mix_out), .mix_valid(mix_valid),
    .busy(busy), .overrun(overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator engine: acks after ack_delay wait cycles; idles with ack high and junk data
  initial begin
    osc_ack  = 1'b0;
    osc_data = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (osc_req) begin
        if (wait_cnt >= ack_delay) begin
          osc_ack  = 1'b1;
          osc_data = data_tbl[osc_voice];
          wait_cnt = 0;
        end else begin
          osc_ack  = 1'b0;
          osc_data = 8'hAA;
          wait_cnt++;
        end
      end else begin
        osc_ack  = 1'b1;
        osc_data = 8'hFF;
        wait_cnt = 0;
      end
    end
  end

  // Output monitor: scoreboard pop on mix_valid, request-hold and overrun tracking
  always @(negedge clk) begin
    if (!nRst) begin
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      if (sample_now && !busy) req_mask <= '0;
      else if (osc_req) req_mask <= req_mask | (NV'(1) << osc_voice);
      if (prev_req && !prev_ack)
        check_val("req_hold", {osc_req, osc_voice}, {1'b1, prev_voice});
      if (mix_valid) begin
        valid_cnt <= valid_cnt + 1;
        valid_cyc <= cyc;
        if (exp_q.size() == 0) check_val("unexpected_valid", mix_valid, 1'b0);
        else check_val("mix_out", mix_out, exp_q.pop_front());
      end
      if (overrun) begin
        ovr_cnt <= ovr_cnt + 1;
        ovr_cyc <= cyc;
      end
      prev_req   <= osc_req;
      prev_ack   <= osc_ack;
      prev_voice <= osc_voice;
    end
  end

  task automatic start_frame(input logic [NV-1:0] en, input int dly, input int exp, input bit push);
    voice_en  = en;
    ack_delay = dly;
    if (push) exp_q.push_back(exp);
    vbase = valid_cnt;
    @(posedge clk);
    #1 sample_now = 1'b1;
    t_start = cyc;
    @(posedge clk);
    #1 sample_now = 1'b0;
  endtask

  task automatic finish_frame(input int exp_off, input logic [NV-1:0] exp_mask);
    int n = 0;
    while (valid_cnt == vbase && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (valid_cnt == vbase) begin
      check_val("valid_timeout", 32'd0, 32'd1);
    end else begin
      check_val("valid_cyc", valid_cyc - t_start, exp_off);
      check_val("busy_in_done", busy, 1'b1);
      check_val("req_mask", req_mask, exp_mask);
      @(negedge clk);
      #1;
      check_val("busy_after", busy, 1'b0);
      check_val("valid_pulse", mix_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRst = 1'b0;
    sample_now = 1'b0;
    voice_en = '0;
    for (int i = 0; i < NV; i++) data_tbl[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_val("rst_mix_out", mix_out, 10'd0);
    check_val("rst_mix_valid", mix_valid, 1'b0);
    check_val("rst_osc_req", osc_req, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_overrun", overrun, 1'b0);
    check_val("rst_osc_voice", osc_voice, 2'd0);
    @(posedge clk);
    #1 nRst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("idle_mix_out", mix_out, 10'd0);
    check_val("idle_busy", busy, 1'b0);
    check_val("idle_osc_req", osc_req, 1'b0);
    check_val("idle_valid_cnt", valid_cnt, 0);

    // Full frame, immediate acks, voice order trace
    data_tbl[0] = 8'd10; data_tbl[1] = 8'd20; data_tbl[2] = 8'd30; data_tbl[3] = 8'd40;
    start_frame(4'b1111, 0, 100, 1'b1);
    for (int k = 1; k <= NV; k++) begin
      @(negedge clk);
      #1;
      check_val("trace_voice", osc_voice, k - 1);
      check_val("trace_req", osc_req, 1'b1);
      check_val("trace_busy", busy, 1'b1);
    end
    finish_frame(5, 4'b1111);

    // Maximum samples, then all voices disabled
    for (int i = 0; i < NV; i++) data_tbl[i] = 8'd255;
    start_frame(4'b1111, 0, 1020, 1'b1);
    finish_frame(5, 4'b1111);
    start_frame(4'b0000, 0, 0, 1'b1);
    finish_frame(5, 4'b0000);

    // Sparse enables, delayed acks, voice_en toggled mid-frame
    data_tbl[0] = 8'd7; data_tbl[1] = 8'd200; data_tbl[2] = 8'd9; data_tbl[3] = 8'd200;
    start_frame(4'b0101, 2, 16, 1'b1);
    @(posedge clk);
    #1 voice_en = 4'b1010;
    finish_frame(9, 4'b0101);
    repeat (3) @(negedge clk);
    #1;
    check_val("mix_hold", mix_out, 10'd16);

    // Strobe during a frame raises overrun and is dropped
    data_tbl[0] = 8'd10; data_tbl[1] = 8'd20; data_tbl[2] = 8'd30; data_tbl[3] = 8'd40;
    obase = ovr_cnt;
    start_frame(4'b1111, 0, 100, 1'b1);
    @(posedge clk);
    #1 sample_now = 1'b1;
    @(posedge clk);
    #1 sample_now = 1'b0;
    finish_frame(5, 4'b1111);
    check_val("ovr_count", ovr_cnt - obase, 1);
    check_val("ovr_cyc", ovr_cyc - t_start, 3);
    repeat (10) @(negedge clk);
    #1;
    check_val("ovr_single_valid", valid_cnt - vbase, 1);
    check_val("ovr_idle", busy, 1'b0);

    // Reset in the middle of a frame
    start_frame(4'b1111, 0, 0, 1'b0);
    @(posedge clk);
    #1 nRst = 1'b0;
    #1;
    check_val("mid_rst_req", osc_req, 1'b0);
    check_val("mid_rst_mix_out", mix_out, 10'd0);
    check_val("mid_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_val("mid_rst_no_valid", valid_cnt - vbase, 0);
    check_val("mid_rst_mix_hold", mix_out, 10'd0);
    start_frame(4'b1111, 0, 100, 1'b1);
    finish_frame(5, 4'b1111);

    check_val("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/voice_mix_scheduler.md
# voice_mix_scheduler

Per-sample voice sequencer for the synthesizer datapath. On each sample-rate strobe from the sample-rate clock divider, it walks the voice slots in order. For each enabled voice it time-multiplexes the single shared oscillator engine through a req/ack handshake. It accumulates the returned samples into one mixed sample and presents that sample to the output stage with a one-cycle valid pulse.

## Interface
- NUM_VOICES, 4, number of voice slots; power of two, ≥2; VW = $clog2(NUM_VOICES)
- SAMPLE_W, 8, unsigned oscillator sample width; MW = SAMPLE_W + VW
- clk  in  1  system clock, all state updates on rising edge
- nRst  in  1  reset, asynchronous, active-low
- sample_now  in  1  one-cycle sample strobe from the divider
- voice_en  in  NUM_VOICES  per-voice enable; bit i = voice i
- osc_req  out  1  request to shared oscillator engine
- osc_voice  out  VW  voice index for the current request
- osc_ack  in  1  oscillator engine accepts request; osc_data valid this cycle
- osc_data  in  SAMPLE_W  unsigned sample for osc_voice
- mix_out  out  MW  unsigned sum of enabled voices for the last completed frame
- mix_valid  out  1  one-cycle pulse: mix_out newly updated
- busy  out  1  frame in progress (state ≠ IDLE)
- overrun  out  1  one-cycle pulse: sample_now arrived while busy

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - sample_now=1 → snapshot voice_en into en_snap, clear acc to 0, set idx to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, current slot idx:
  - osc_voice = idx.
  - osc_req = en_snap[idx] (combinational from registered state).
  - If en_snap[idx]=0 → skip the slot in one cycle; no request; acc unchanged.
  - If en_snap[idx]=1 → hold osc_req high until a cycle with osc_ack=1. On that cycle acc += osc_data (zero-extended to MW).
  - osc_ack is ignored when osc_req=0.
  - When a slot completes (skip or ack): if idx = NUM_VOICES-1, load mix_out with the final sum (including this cycle's osc_data) and go to DONE; otherwise idx+1.
- DONE: mix_valid=1 for this cycle; go to IDLE unconditionally.
- sample_now in RUN or DONE → overrun=1 the following cycle. The strobe is dropped; the current frame continues undisturbed.
- voice_en changes after the snapshot have no effect until the next frame.
- Arithmetic: unsigned, MW bits; the sum of NUM_VOICES max samples fits, so no overflow or saturation.
- All enables zero: frame still runs NUM_VOICES skip cycles, then mix_out=0 with mix_valid pulse.
- mix_out holds its value between frames.

## Timing
- Reset values:
  - state IDLE, idx 0, en_snap 0, acc 0.
  - mix_out 0, mix_valid 0, busy 0, overrun 0.
  - osc_req 0, osc_voice 0.
- Reset mid-frame: osc_req falls asynchronously; frame aborted; no mix_valid. The next sample_now after release starts a fresh frame.
- sample_now sampled in cycle t (IDLE):
  - RUN begins at t+1 with voice 0.
  - busy high from t+1 through the DONE cycle.
- Each enabled slot takes 1 + (ack wait cycles) cycles; each disabled slot takes 1 cycle.
- Zero-wait acks: slots occupy t+1..t+NUM_VOICES, DONE/mix_valid at t+NUM_VOICES+1, IDLE at t+NUM_VOICES+2.
- mix_out changes on the same edge that mix_valid rises.
- Divider period 256 ≫ NUM_VOICES: overrun occurs only with excessive ack latency.

## Test plan
- Reset: hold nRst=0 → mix_out=0, mix_valid=0, osc_req=0, busy=0. Release; no sample_now → all outputs stay 0.
- NUM_VOICES=4, voice_en=4'b1111, immediate ack, osc_data 10/20/30/40:
  - osc_voice 0,1,2,3 at t+1..t+4.
  - mix_valid only at t+5 with mix_out=100.
  - busy low at t+6.
- All osc_data=255, all enabled → mix_out=10'h3FC. Then voice_en=0 → next frame mix_out=0, mix_valid at t+5, osc_req never high.
- voice_en=4'b0101, ack delayed 2 cycles per request, data 7 and 9:
  - Only voices 0 and 2 are requested; osc_req held until ack.
  - mix_out=16, mix_valid at t+9.
  - Toggling voice_en mid-frame does not change the result.
- sample_now pulsed at t+2 during a frame → overrun pulse at t+3; frame completes with correct sum; exactly one mix_valid.
- nRst asserted at t+2 of a frame → osc_req drops immediately, mix_out=0, no mix_valid. After release, the next frame produces the correct sum.
